exception_ctrl: RTL and testbench
=================================

Name: exception_ctrl

Overview:
Commit-stage exception/interrupt sequencer for the dual-issue pipeline.
- Inputs: per-slot exception requests from the two commit slots, plus live CP0 status/cause/epc/ebase.
- Picks one winning event, pulses the CP0 update strobe (flag/type/first-inst), and flushes the pipeline for a fixed number of cycles.
- Then hands the fetch unit a redirect PC through a valid/ready handshake.
- Sits between the commit stage, the CP0 register file and the PC/fetch unit.

Parameters:
FLUSH_CYCLES, 2, cycles flush_o is held after the CP0 strobe (min 1)
VEC_OFFSET, 32'h0000_0000, added to ebase_i to form the exception vector

Ports:
clk  in  1  single clock
resetn  in  1  asynchronous, active-low reset
slot1_exc_valid_i  in  1  slot 1 raises an exception/ERET this cycle
slot1_exc_code_i  in  5  slot 1 ExcCode (package constants)
slot1_valid_i  in  1  slot 1 holds a real committing instruction
slot2_exc_valid_i  in  1  slot 2 raises an exception/ERET
slot2_exc_code_i  in  5  slot 2 ExcCode
commit_stall_i  in  1  commit stage stalled; no event accepted this cycle
int_i  in  6  external hardware interrupt lines
status_i  in  32  CP0 Status (IE=bit0, EXL=bit1, IM=15:8)
cause_i  in  32  CP0 Cause (IP=15:8)
epc_i  in  32  CP0 EPC
ebase_i  in  32  CP0 EBase
redirect_ready_i  in  1  fetch accepts redirect
exception_flag_o  out  1  one-cycle CP0 update strobe
exception_type_o  out  5  ExcCode of winning event
exception_first_inst_o  out  1  1 = event belongs to slot 1
flush_o  out  1  flush all stages younger than commit
redirect_valid_o  out  1  redirect PC valid
redirect_pc_o  out  32  new fetch PC
busy_o  out  1  FSM not IDLE; commit must hold

Behaviour:
- Reset (resetn=0, async): state=IDLE, counter=0, every output 0.
- int_pending = |(ip & status_i[15:8]) & status_i[0] & ~status_i[1]; ip = cause_i[15:8] (see Optional Feature).
- Event selection in IDLE when commit_stall_i=0, priority high to low:
  1. int_pending & slot1_valid_i: type INT, first_inst=1.
  2. slot1_exc_valid_i: slot1 code, first_inst=1.
  3. slot2_exc_valid_i: slot2 code, first_inst=0.
  - Slot 2 is ignored whenever slot 1 has an exception or an interrupt is taken.
  - Interrupt with slot1_valid_i=0 is not taken; it stays pending and is re-evaluated next cycle.
- FSM states: IDLE, STROBE, FLUSH, REDIRECT.
  - IDLE -> STROBE on a selected event (cycle T).
  - STROBE (T+1): exception_flag_o=1, type/first_inst registered, flush_o=1, counter=FLUSH_CYCLES-1. Next: FLUSH if counter>0, else REDIRECT.
  - FLUSH: flush_o=1, counter decrements each cycle; at 0 go to REDIRECT.
  - REDIRECT: redirect_valid_o=1, flush_o=0. redirect_pc_o is held stable until redirect_ready_i=1, then IDLE. Ready in the same cycle valid first rises completes the handshake.
- redirect_pc_o:
  - ERET (code 5'h0E): epc_i as sampled at T+1. The CP0 strobe has not yet written EPC for ERET.
  - Otherwise: ebase_i + VEC_OFFSET, 32-bit add, carry dropped, sampled at T+1.
- exception_flag_o is high exactly one cycle per event; type/first_inst are 0 except in STROBE.
- busy_o=1 in STROBE/FLUSH/REDIRECT. All slot inputs are ignored while busy.
- commit_stall_i=1 in IDLE: no selection. A pending request must be re-presented by commit.
- resetn falling in any state: immediate return to IDLE, outputs cleared, handshake abandoned.

Optional Feature:
EXC_CTRL_INT_SYNC_EN
- Defined: int_i passes through a 2-flop synchronizer (reset 0), and ip = {sync_int[5:0], cause_i[9:8]}. Adds 2-cycle interrupt latency.
- Undefined: int_i is unused and ip = cause_i[15:8].

Decomposition:
- Shared package/defines: ExcCode constants INT=5'h00, ADEL=5'h04, ADES=5'h05, SYS=5'h08, BP=5'h09, RI=5'h0A, OV=5'h0C, TR=5'h0D, ERET=5'h0E; FSM state encodings; Status/Cause bit-index constants.
- One sub-module: exc_priority_sel (combinational selection of winner, type and first_inst).

Test Plan:
1. Slot1 SYS (8) at T, FLUSH_CYCLES=2, ebase_i=32'hBFC0_0380, ready=1 → flag=1, type=8, first_inst=1 at T+1; flush_o high T+1..T+2; redirect_valid_o=1, redirect_pc_o=32'hBFC0_0380 at T+3; IDLE at T+4.
2. Slot2 OV (12) only, slot1 clean → type=12, first_inst=0. Same cycle slot1 RI (10) + slot2 OV → type=10, first_inst=1.
3. ERET on slot1, epc_i=32'h8000_1234 → type=14, redirect_pc_o=32'h8000_1234.
4. status_i=32'h0000_0401, cause_i IP2 set, slot1_valid_i=1 → type=0. Repeat with status_i[1]=1 → no event. Repeat with slot1_valid_i=0 → no event until a valid slot 1 arrives.
5. redirect_ready_i low for 5 cycles → redirect_valid_o/pc held stable, busy_o=1, new slot exceptions ignored; accepted when ready rises.
6. resetn pulsed low during FLUSH → all outputs 0 asynchronously, state IDLE. Macro build: int_i[0] toggle reaches int_pending 2 cycles later.

Source files
------------

// File: rtl/exception_ctrl_pkg.sv
// Shared definitions for the commit-stage exception sequencer: ExcCodes,
// FSM state encoding and CP0 Status/Cause bit positions.
package exception_ctrl_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;
  localparam logic [4:0] EXC_TR   = 5'h0D;
  localparam logic [4:0] EXC_ERET = 5'h0E;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int IM_LO      = 8;
  localparam int IM_HI      = 15;
  localparam int IP_LO      = 8;
  localparam int IP_HI      = 15;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STROBE   = 2'd1,
    S_FLUSH    = 2'd2,
    S_REDIRECT = 2'd3
  } state_e;

endpackage

// File: rtl/exception_ctrl_exc_priority_sel.sv
// Combinational winner selection among interrupt, slot 1 and slot 2 events.
module exc_priority_sel
  import exception_ctrl_pkg::*;
(
  input  logic       int_pending_i,
  input  logic       slot1_valid_i,
  input  logic       slot1_exc_valid_i,
  input  logic [4:0] slot1_exc_code_i,
  input  logic       slot2_exc_valid_i,
  input  logic [4:0] slot2_exc_code_i,
  output logic       sel_valid_o,
  output logic [4:0] sel_code_o,
  output logic       sel_first_o
);

  // An interrupt needs a real slot-1 instruction to attach its EPC to.
  always_comb begin
    sel_valid_o = 1'b0;
    sel_code_o  = 5'h00;
    sel_first_o = 1'b0;
    if (int_pending_i && slot1_valid_i) begin
      sel_valid_o = 1'b1;
      sel_code_o  = EXC_INT;
      sel_first_o = 1'b1;
    end else if (slot1_exc_valid_i) begin
      sel_valid_o = 1'b1;
      sel_code_o  = slot1_exc_code_i;
      sel_first_o = 1'b1;
    end else if (slot2_exc_valid_i) begin
      sel_valid_o = 1'b1;
      sel_code_o  = slot2_exc_code_i;
      sel_first_o = 1'b0;
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// Commit-stage exception/interrupt sequencer: CP0 strobe, flush, then redirect.
// Optional macro EXC_CTRL_INT_SYNC_EN routes int_i through a 2-flop synchronizer.
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] VEC_OFFSET   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        slot1_exc_valid_i,
  input  logic [4:0]  slot1_exc_code_i,
  input  logic        slot1_valid_i,
  input  logic        slot2_exc_valid_i,
  input  logic [4:0]  slot2_exc_code_i,
  input  logic        commit_stall_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] ebase_i,
  input  logic        redirect_ready_i,
  output logic        exception_flag_o,
  output logic [4:0]  exception_type_o,
  output logic        exception_first_inst_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o
);

  localparam logic [7:0] CNT_INIT = 8'(FLUSH_CYCLES - 1);

  logic [7:0] ip;
  logic       int_pending;
  logic       unused_bits;

`ifdef EXC_CTRL_INT_SYNC_EN
  logic [5:0] int_meta_q, int_sync_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      int_meta_q <= 6'h00;
      int_sync_q <= 6'h00;
    end else begin
      int_meta_q <= int_i;
      int_sync_q <= int_meta_q;
    end
  end

  assign ip          = {int_sync_q, cause_i[IP_LO+1:IP_LO]};
  assign unused_bits = ^{cause_i[31:IP_LO+2], cause_i[IP_LO-1:0],
                         status_i[31:IM_HI+1], status_i[IM_LO-1:STATUS_EXL+1]};
`else
  assign ip          = cause_i[IP_HI:IP_LO];
  assign unused_bits = ^{int_i, cause_i[31:IP_HI+1], cause_i[IP_LO-1:0],
                         status_i[31:IM_HI+1], status_i[IM_LO-1:STATUS_EXL+1]};
`endif

  assign int_pending = (|(ip & status_i[IM_HI:IM_LO])) & status_i[STATUS_IE]
                       & ~status_i[STATUS_EXL];

  logic       sel_valid;
  logic [4:0] sel_code;
  logic       sel_first;

  exc_priority_sel u_sel (
    .int_pending_i     (int_pending),
    .slot1_valid_i     (slot1_valid_i),
    .slot1_exc_valid_i (slot1_exc_valid_i),
    .slot1_exc_code_i  (slot1_exc_code_i),
    .slot2_exc_valid_i (slot2_exc_valid_i),
    .slot2_exc_code_i  (slot2_exc_code_i),
    .sel_valid_o       (sel_valid),
    .sel_code_o        (sel_code),
    .sel_first_o       (sel_first)
  );

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        flag_q, flag_d;
  logic [4:0]  type_q, type_d;
  logic        first_q, first_d;
  logic        flush_q, flush_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic        busy_q, busy_d;

  // Outputs are computed for the next state so every one of them is a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flag_d  = 1'b0;
    type_d  = 5'h00;
    first_d = 1'b0;
    flush_d = 1'b0;
    valid_d = 1'b0;
    pc_d    = pc_q;
    busy_d  = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        pc_d   = 32'h0;
        if (!commit_stall_i && sel_valid) begin
          state_d = S_STROBE;
          cnt_d   = CNT_INIT;
          flag_d  = 1'b1;
          type_d  = sel_code;
          first_d = sel_first;
          flush_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_STROBE: begin
        // EPC is read here because CP0 leaves it untouched for ERET.
        pc_d = (type_q == EXC_ERET) ? epc_i : (ebase_i + VEC_OFFSET);
        if (cnt_q != 8'd0) begin
          state_d = S_FLUSH;
          flush_d = 1'b1;
        end else begin
          state_d = S_REDIRECT;
          valid_d = 1'b1;
        end
      end
      S_FLUSH: begin
        if (cnt_q <= 8'd1) begin
          cnt_d   = 8'd0;
          state_d = S_REDIRECT;
          valid_d = 1'b1;
        end else begin
          cnt_d   = cnt_q - 8'd1;
          flush_d = 1'b1;
        end
      end
      S_REDIRECT: begin
        if (redirect_ready_i) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          pc_d    = 32'h0;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      flag_q  <= 1'b0;
      type_q  <= 5'h00;
      first_q <= 1'b0;
      flush_q <= 1'b0;
      valid_q <= 1'b0;
      pc_q    <= 32'h0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      type_q  <= type_d;
      first_q <= first_d;
      flush_q <= flush_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      busy_q  <= busy_d;
    end
  end

  assign exception_flag_o       = flag_q;
  assign exception_type_o       = type_q;
  assign exception_first_inst_o = first_q;
  assign flush_o                = flush_q;
  assign redirect_valid_o       = valid_q;
  assign redirect_pc_o          = pc_q;
  assign busy_o                 = busy_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed self-checking bench for exception_ctrl (FLUSH_CYCLES=2, VEC_OFFSET=0).
module tb_exception_ctrl;
  import exception_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        slot1_exc_valid_i = 1'b0;
  logic [4:0]  slot1_exc_code_i = 5'h0;
  logic        slot1_valid_i = 1'b0;
  logic        slot2_exc_valid_i = 1'b0;
  logic [4:0]  slot2_exc_code_i = 5'h0;
  logic        commit_stall_i = 1'b0;
  logic [5:0]  int_i = 6'h0;
  logic [31:0] status_i = 32'h0;
  logic [31:0] cause_i = 32'h0;
  logic [31:0] epc_i = 32'h0;
  logic [31:0] ebase_i = 32'h0;
  logic        redirect_ready_i = 1'b0;
  logic        exception_flag_o;
  logic [4:0]  exception_type_o;
  logic        exception_first_inst_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  exception_ctrl dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .slot1_exc_valid_i      (slot1_exc_valid_i),
    .slot1_exc_code_i       (slot1_exc_code_i),
    .slot1_valid_i          (slot1_valid_i),
    .slot2_exc_valid_i      (slot2_exc_valid_i),
    .slot2_exc_code_i       (slot2_exc_code_i),
    .commit_stall_i         (commit_stall_i),
    .int_i                  (int_i),
    .status_i               (status_i),
    .cause_i                (cause_i),
    .epc_i                  (epc_i),
    .ebase_i                (ebase_i),
    .redirect_ready_i       (redirect_ready_i),
    .exception_flag_o       (exception_flag_o),
    .exception_type_o       (exception_type_o),
    .exception_first_inst_o (exception_first_inst_o),
    .flush_o                (flush_o),
    .redirect_valid_o       (redirect_valid_o),
    .redirect_pc_o          (redirect_pc_o),
    .busy_o                 (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s1v, input logic s1e, input logic [4:0] s1c,
                               input logic s2e, input logic [4:0] s2c);
    slot1_valid_i     = s1v;
    slot1_exc_valid_i = s1e;
    slot1_exc_code_i  = s1c;
    slot2_exc_valid_i = s2e;
    slot2_exc_code_i  = s2c;
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (!busy_o) break;
      tick();
    end
    checkOutput(tag, {31'h0, busy_o}, 32'h0);
  endtask

  initial begin
    ebase_i          = 32'hBFC0_0380;
    redirect_ready_i = 1'b1;
    #2;
    checkOutput("reset_outputs",
                {19'h0, exception_flag_o, exception_type_o, exception_first_inst_o,
                 flush_o, redirect_valid_o, busy_o, 3'h0},
                32'h0);
    checkOutput("reset_pc", redirect_pc_o, 32'h0);
    tick();
    resetn = 1'b1;
    tick();

    // Slot 1 SYS through the full strobe / flush / redirect sequence
    applyStimulus(1, 1, EXC_SYS, 0, 5'h0);
    tick();
    checkOutput("t1_flag", {31'h0, exception_flag_o}, 32'h1);
    checkOutput("t1_type", {27'h0, exception_type_o}, 32'h8);
    checkOutput("t1_first", {31'h0, exception_first_inst_o}, 32'h1);
    checkOutput("t1_flush_a", {31'h0, flush_o}, 32'h1);
    checkOutput("t1_busy", {31'h0, busy_o}, 32'h1);
    applyStimulus(0, 0, 5'h0, 0, 5'h0);
    tick();
    checkOutput("t1_flag_low", {31'h0, exception_flag_o}, 32'h0);
    checkOutput("t1_type_low", {27'h0, exception_type_o}, 32'h0);
    checkOutput("t1_flush_b", {31'h0, flush_o}, 32'h1);
    checkOutput("t1_valid_early", {31'h0, redirect_valid_o}, 32'h0);
    tick();
    checkOutput("t1_flush_c", {31'h0, flush_o}, 32'h0);
    checkOutput("t1_valid", {31'h0, redirect_valid_o}, 32'h1);
    checkOutput("t1_pc", redirect_pc_o, 32'hBFC0_0380);
    tick();
    checkOutput("t1_valid_done", {31'h0, redirect_valid_o}, 32'h0);
    checkOutput("t1_busy_done", {31'h0, busy_o}, 32'h0);

    // Slot 2 alone, then slot 1 overriding slot 2
    applyStimulus(1, 0, 5'h0, 1, EXC_OV);
    tick();
    checkOutput("t2a_type", {27'h0, exception_type_o}, 32'hC);
    checkOutput("t2a_first", {31'h0, exception_first_inst_o}, 32'h0);
    applyStimulus(0, 0, 5'h0, 0, 5'h0);
    waitIdle("t2a_idle");
    applyStimulus(1, 1, EXC_RI, 1, EXC_OV);
    tick();
    checkOutput("t2b_type", {27'h0, exception_type_o}, 32'hA);
    checkOutput("t2b_first", {31'h0, exception_first_inst_o}, 32'h1);
    applyStimulus(0, 0, 5'h0, 0, 5'h0);
    waitIdle("t2b_idle");

    // ERET redirects to EPC
    epc_i = 32'h8000_1234;
    applyStimulus(1, 1, EXC_ERET, 0, 5'h0);
    tick();
    checkOutput("t3_type", {27'h0, exception_type_o}, 32'hE);
    applyStimulus(0, 0, 5'h0, 0, 5'h0);
    tick();
    tick();
    checkOutput("t3_valid", {31'h0, redirect_valid_o}, 32'h1);
    checkOutput("t3_pc", redirect_pc_o, 32'h8000_1234);
    waitIdle("t3_idle");

    // Interrupt taken, masked by EXL, and deferred without a valid slot 1
    status_i = 32'h0000_0401;
    cause_i  = 32'h0000_0400;
    applyStimulus(1, 0, 5'h0, 0, 5'h0);
    tick();
    checkOutput("t4_int_flag", {31'h0, exception_flag_o}, 32'h1);
    checkOutput("t4_int_type", {27'h0, exception_type_o}, 32'h0);
    checkOutput("t4_int_first", {31'h0, exception_first_inst_o}, 32'h1);
    cause_i = 32'h0;
    applyStimulus(0, 0, 5'h0, 0, 5'h0);
    waitIdle("t4_idle");
    status_i = 32'h0000_0403;
    cause_i  = 32'h0000_0400;
    applyStimulus(1, 0, 5'h0, 0, 5'h0);
    tick();
    checkOutput("t4_exl_busy", {31'h0, busy_o}, 32'h0);
    status_i = 32'h0000_0401;
    applyStimulus(0, 0, 5'h0, 0, 5'h0);
    tick();
    checkOutput("t4_noslot_a", {31'h0, busy_o}, 32'h0);
    tick();
    checkOutput("t4_noslot_b", {31'h0, exception_flag_o}, 32'h0);
    applyStimulus(1, 0, 5'h0, 0, 5'h0);
    tick();
    checkOutput("t4_late_flag", {31'h0, exception_flag_o}, 32'h1);
    checkOutput("t4_late_type", {27'h0, exception_type_o}, 32'h0);
    cause_i  = 32'h0;
    status_i = 32'h0;
    applyStimulus(0, 0, 5'h0, 0, 5'h0);
    waitIdle("t4_late_idle");

    // Redirect back-pressure; new exceptions ignored while busy
    redirect_ready_i = 1'b0;
    applyStimulus(1, 1, EXC_SYS, 0, 5'h0);
    tick();
    applyStimulus(1, 1, EXC_BP, 1, EXC_OV);
    tick();
    tick();
    checkOutput("t5_valid", {31'h0, redirect_valid_o}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t5_hold_valid", {31'h0, redirect_valid_o}, 32'h1);
      checkOutput("t5_hold_pc", redirect_pc_o, 32'hBFC0_0380);
      checkOutput("t5_hold_busy", {31'h0, busy_o}, 32'h1);
      checkOutput("t5_hold_flag", {31'h0, exception_flag_o}, 32'h0);
    end
    applyStimulus(0, 0, 5'h0, 0, 5'h0);
    redirect_ready_i = 1'b1;
    tick();
    checkOutput("t5_accept_valid", {31'h0, redirect_valid_o}, 32'h0);
    checkOutput("t5_accept_busy", {31'h0, busy_o}, 32'h0);

    // Commit stall blocks selection
    commit_stall_i = 1'b1;
    applyStimulus(1, 1, EXC_SYS, 0, 5'h0);
    tick();
    checkOutput("stall_busy", {31'h0, busy_o}, 32'h0);
    commit_stall_i = 1'b0;
    tick();
    checkOutput("unstall_flag", {31'h0, exception_flag_o}, 32'h1);
    applyStimulus(0, 0, 5'h0, 0, 5'h0);
    waitIdle("unstall_idle");

    // Asynchronous reset in the middle of FLUSH
    applyStimulus(1, 1, EXC_ADEL, 0, 5'h0);
    tick();
    applyStimulus(0, 0, 5'h0, 0, 5'h0);
    tick();
    checkOutput("t6_in_flush", {31'h0, flush_o}, 32'h1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("t6_async_outputs",
                {19'h0, exception_flag_o, exception_type_o, exception_first_inst_o,
                 flush_o, redirect_valid_o, busy_o, 3'h0},
                32'h0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    checkOutput("t6_after_busy", {31'h0, busy_o}, 32'h0);

`ifdef EXC_CTRL_INT_SYNC_EN
    // int_i[0] feeds IP2 two flops later
    status_i = 32'h0000_0401;
    cause_i  = 32'h0;
    applyStimulus(1, 0, 5'h0, 0, 5'h0);
    int_i = 6'h01;
    tick();
    checkOutput("sync_stage1", {31'h0, exception_flag_o}, 32'h0);
    tick();
    checkOutput("sync_stage2", {31'h0, exception_flag_o}, 32'h0);
    tick();
    checkOutput("sync_taken", {31'h0, exception_flag_o}, 32'h1);
    int_i    = 6'h00;
    status_i = 32'h0;
    applyStimulus(0, 0, 5'h0, 0, 5'h0);
    waitIdle("sync_idle");
`else
    // Without the synchronizer int_i has no effect
    status_i = 32'h0000_FF01;
    cause_i  = 32'h0;
    int_i    = 6'h3F;
    applyStimulus(1, 0, 5'h0, 0, 5'h0);
    tick();
    checkOutput("int_ignored_a", {31'h0, busy_o}, 32'h0);
    tick();
    checkOutput("int_ignored_b", {31'h0, exception_flag_o}, 32'h0);
    int_i    = 6'h00;
    status_i = 32'h0;
    applyStimulus(0, 0, 5'h0, 0, 5'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
